snd_cmd_mailbox: RTL

- Parametrised host-to-sound-CPU command channel. Replaces the single sound-code latch and edge-triggered Z80 IRQ flip-flop in the audio subsystem.
- Host (68K) writes are buffered in a FIFO of depth DEPTH, and the sound CPU pops them through its comm-register read.
- IRQ generation is selectable: host-triggered latched IRQ, or a level "data pending" IRQ.
- Adds a one-entry reply latch for the sound-to-host direction and sticky overflow status.

---
 rtl/snd_pkg.sv | 24 ++
 rtl/snd_cmd_mailbox_if.sv | 46 ++++
 rtl/snd_fifo.sv | 107 ++++++++++
 rtl/snd_cmd_mailbox.sv | 115 +++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snd_pkg
//  Brief    : Shared constants and sizing helpers for the sound command
//             mailbox (IRQ mode encodings, count/pointer widths).
//  Revision : 1.0 - initial release
// ============================================================================
package snd_pkg;

    localparam int IRQ_MODE_LATCH = 0;
    localparam int IRQ_MODE_LEVEL = 1;

    // Width needed to hold an occupancy value of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; a single-entry FIFO still carries a one-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snd_cmd_mailbox_if.sv
`default_nettype none
// ============================================================================
//  Module   : snd_cmd_mailbox_if
//  Brief    : Host / sound-CPU signal bundle for the command mailbox.
//             master = bus side driving requests, slave = mailbox.
//  Revision : 1.0 - initial release
// ============================================================================
interface snd_cmd_mailbox_if
    import snd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    logic [DATA_W-1:0]         host_data;
    logic                      host_strobe;
    logic                      host_irq;
    logic                      snd_rd;
    logic [DATA_W-1:0]         snd_data;
    logic                      snd_iack;
    logic                      irq_n;
    logic [DATA_W-1:0]         snd_reply_data;
    logic                      snd_reply_wr;
    logic [DATA_W-1:0]         host_reply;
    logic                      host_reply_valid;
    logic                      host_reply_rd;
    logic [cnt_w(DEPTH)-1:0]   fifo_count;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      overflow;
    logic                      ovf_clr;

    modport master (
        output host_data, host_strobe, host_irq, snd_rd, snd_iack,
               snd_reply_data, snd_reply_wr, host_reply_rd, ovf_clr,
        input  snd_data, irq_n, host_reply, host_reply_valid,
               fifo_count, fifo_empty, fifo_full, overflow
    );

    modport slave (
        input  host_data, host_strobe, host_irq, snd_rd, snd_iack,
               snd_reply_data, snd_reply_wr, host_reply_rd, ovf_clr,
        output snd_data, irq_n, host_reply, host_reply_valid,
               fifo_count, fifo_empty, fifo_full, overflow
    );
endinterface
`default_nettype wire

// File: rtl/snd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : snd_fifo
//  Brief    : First-word-fall-through FIFO with optional overwrite-newest
//             on full. When empty the head shows the last popped word.
//  Revision : 1.0 - initial release
// ============================================================================
module snd_fifo
    import snd_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 0
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       head,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    empty,
    output logic                    full,
    output logic                    empty_nxt,
    output logic                    ovf_event
);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic [DATA_W-1:0] last_pop_q, last_pop_d;
    logic              do_pop;
    logic              push_acc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
    endfunction

    // Pop is evaluated first, so a full FIFO popped and pushed together
    // accepts the new word into the slot the pop frees.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        last_pop_d = last_pop_q;
        ovf_event  = 1'b0;
        push_acc   = 1'b0;
        do_pop     = pop & ~empty_q;
        if (do_pop) begin
            last_pop_d = mem_q[rd_ptr_q];
            rd_ptr_d   = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            if (!full_q || do_pop) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
                push_acc        = 1'b1;
            end else if (OVERWRITE != 0) begin
                mem_d[ptr_dec(wr_ptr_q)] = push_data;
            end else begin
                ovf_event = 1'b1;
            end
        end
        count_d   = count_q + CNT_W'(push_acc) - CNT_W'(do_pop);
        empty_d   = (count_d == '0);
        full_d    = (count_d == CNT_W'(DEPTH));
        empty_nxt = empty_d;
    end

    // Storage, pointers and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            last_pop_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            last_pop_q <= last_pop_d;
        end
    end

    assign head  = empty_q ? last_pop_q : mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule
`default_nettype wire

// File: rtl/snd_cmd_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : snd_cmd_mailbox
//  Brief    : Host-to-sound-CPU command mailbox: strobe-edge FIFO push,
//             selectable latched/level IRQ, reply latch, sticky overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module snd_cmd_mailbox
    import snd_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 0,
    parameter int IRQ_MODE  = IRQ_MODE_LATCH
)(
    input  logic               clk_main,
    input  logic               reset,
    snd_cmd_mailbox_if.slave   bus
);
    logic              strobe_prev_q, strobe_prev_d;
    logic              irq_prev_q, irq_prev_d;
    logic              irq_n_q, irq_n_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] reply_q, reply_d;
    logic              reply_v_q, reply_v_d;
    logic              strobe_edge;
    logic              irq_edge;
    logic              fifo_empty_nxt;
    logic              fifo_ovf_event;

    assign strobe_edge = bus.host_strobe & ~strobe_prev_q;
    assign irq_edge    = bus.host_irq & ~irq_prev_q;

    snd_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE)
    ) u_fifo (
        .clk       (clk_main),
        .rst       (reset),
        .push      (strobe_edge),
        .push_data (bus.host_data),
        .pop       (bus.snd_rd),
        .head      (bus.snd_data),
        .count     (bus.fifo_count),
        .empty     (bus.fifo_empty),
        .full      (bus.fifo_full),
        .empty_nxt (fifo_empty_nxt),
        .ovf_event (fifo_ovf_event)
    );

    // Edge history, sticky overflow (new event beats clear) and reply latch
    // (write beats read).
    always_comb begin
        strobe_prev_d = bus.host_strobe;
        irq_prev_d    = bus.host_irq;
        ovf_d         = ovf_q;
        reply_d       = reply_q;
        reply_v_d     = reply_v_q;
        if (bus.ovf_clr)       ovf_d = 1'b0;
        if (fifo_ovf_event)    ovf_d = 1'b1;
        if (bus.host_reply_rd) reply_v_d = 1'b0;
        if (bus.snd_reply_wr) begin
            reply_d   = bus.snd_reply_data;
            reply_v_d = 1'b1;
        end
    end

    generate
        if (IRQ_MODE == IRQ_MODE_LEVEL) begin : g_irq_level
            logic unused_level;
            assign unused_level = bus.snd_iack ^ irq_edge;
            // IRQ follows "data pending" of the next FIFO state.
            always_comb begin
                irq_n_d = fifo_empty_nxt;
            end
        end else begin : g_irq_latch
            logic unused_latch;
            assign unused_latch = fifo_empty_nxt;
            // Host edge raises the request; acknowledge wins over a new edge.
            always_comb begin
                irq_n_d = irq_n_q;
                if (irq_edge)     irq_n_d = 1'b0;
                if (bus.snd_iack) irq_n_d = 1'b1;
            end
        end
    endgenerate

    // Control registers; histories reset high so a level held through reset
    // release is not mistaken for an edge.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            strobe_prev_q <= 1'b1;
            irq_prev_q    <= 1'b1;
            irq_n_q       <= 1'b1;
            ovf_q         <= 1'b0;
            reply_q       <= '0;
            reply_v_q     <= 1'b0;
        end else begin
            strobe_prev_q <= strobe_prev_d;
            irq_prev_q    <= irq_prev_d;
            irq_n_q       <= irq_n_d;
            ovf_q         <= ovf_d;
            reply_q       <= reply_d;
            reply_v_q     <= reply_v_d;
        end
    end

    assign bus.irq_n            = irq_n_q;
    assign bus.overflow         = ovf_q;
    assign bus.host_reply       = reply_q;
    assign bus.host_reply_valid = reply_v_q;

endmodule
`default_nettype wire
